axi_arbiter: RTL and testbench
==============================

# axi_arbiter

Two-master to one-slave AXI4 arbiter between the core's instruction fetch unit (master 0, read-only) and load/store unit (master 1, read/write). It feeds the memory slave (the DPI-backed SRAM model) through a single shared AXI port. It allows exactly one outstanding transaction at a time, granted per whole transaction with round-robin fairness. All transactions are single-beat (len 0, INCR, 32-bit data).

## Interface
Parameters:
- none; data width 32, address width 32, id width 4 are fixed.

Ports (clock and reset first; `a / b` lines are handshake pairs, directions listed in the same order):
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- m0_arvalid / m0_arready  in / out  1  IFU read-address handshake.
- m0_araddr  in  32  IFU read address.
- m0_arsize  in  3  IFU transfer size.
- m0_rvalid / m0_rready  out / in  1  IFU read-data handshake.
- m0_rdata  out  32  IFU read data.
- m0_rresp  out  2  IFU read response.
- m1_arvalid / m1_arready  in / out  1  LSU read-address handshake.
- m1_araddr  in  32  LSU read address.
- m1_arsize  in  3  LSU transfer size.
- m1_rvalid / m1_rready  out / in  1  LSU read-data handshake.
- m1_rdata  out  32  LSU read data.
- m1_rresp  out  2  LSU read response.
- m1_awvalid / m1_awready  in / out  1  LSU write-address handshake.
- m1_awaddr  in  32  LSU write address.
- m1_awsize  in  3  LSU write size.
- m1_wvalid / m1_wready  in / out  1  LSU write-data handshake.
- m1_wdata  in  32  LSU write data.
- m1_wstrb  in  4  LSU byte strobes.
- m1_bvalid / m1_bready  out / in  1  LSU write-response handshake.
- m1_bresp  out  2  LSU write response.
- s_arvalid / s_arready  out / in  1  slave read-address handshake.
- s_araddr  out  32  slave read address.
- s_arid  out  4  slave read id.
- s_arlen  out  8  slave burst length.
- s_arsize  out  3  slave transfer size.
- s_arburst  out  2  slave burst type.
- s_rvalid / s_rready  in / out  1  slave read-data handshake.
- s_rdata  in  32  slave read data.
- s_rresp  in  2  slave read response.
- s_rlast  in  1  slave last beat; ignored.
- s_rid  in  4  slave read id; ignored.
- s_awvalid / s_awready  out / in  1  slave write-address handshake.
- s_awaddr  out  32  slave write address.
- s_awid  out  4  slave write id.
- s_awlen  out  8  slave burst length.
- s_awsize  out  3  slave write size.
- s_awburst  out  2  slave burst type.
- s_wvalid / s_wready  out / in  1  slave write-data handshake.
- s_wdata  out  32  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_wlast  out  1  slave last beat.
- s_bvalid / s_bready  in / out  1  slave write-response handshake.
- s_bresp  in  2  slave write response.
- s_bid  in  4  slave write id; ignored.

## Operation
- States: IDLE, RD0 (m0 read), RD1 (m1 read), WR (m1 write). Flags: addr_done (AR or AW accepted), wdat_done (W accepted). Register last_grant (1 bit).
- IDLE: req0 = m0_arvalid; req1 = m1_arvalid | m1_awvalid. When m1 has both, m1_arvalid wins (RD1).
- Arbitration in IDLE:
  - single requester is granted;
  - on both requesting, grant the master != last_grant;
  - last_grant updates on every grant.
- Granted state: master AR/AW/W channels are routed to the slave combinationally.
  - s_*valid = master valid & !done flag; master ready = slave ready & !done flag.
  - addr_done sets on AR/AW handshake; wdat_done sets on W handshake; both clear on entry to IDLE.
- Granted state, response path: R or B channel routed slave→granted master combinationally.
- Non-granted master: all of its ready and valid outputs are 0.
- Completion returns to IDLE on the next edge:
  - RDx: on s_rvalid & s_rready (s_rlast ignored; slave ties it 0);
  - WR: on s_bvalid & s_bready.
- Constant fields: s_arlen = s_awlen = 0, s_arburst = s_awburst = 2'b01, s_wlast = 1. s_arid = 0 in RD0, 1 in RD1; s_awid = 1.
- In IDLE, slave data/address outputs are 0.
- m*_rdata, rresp, bresp pass through only while that master is granted, else 0.

## Timing
- Reset (async): state IDLE, addr_done = wdat_done = 0, last_grant = 1 (m0 wins first tie). Every valid/ready output is 0 and all data outputs are 0 while reset is high.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N means s_arvalid/s_awvalid is high after edge N.
- Back-to-back: the cycle after completion is IDLE; minimum of 1 idle cycle between transactions.
- AW and W may handshake in the same cycle or in either order. The slave orders them itself; the arbiter does not reorder.
- Master requests arriving mid-transaction wait with ready = 0 and are evaluated in the next IDLE.
- Reset mid-transaction drops the grant immediately. The shared reset also resets the slave, so no transaction is replayed.

## Test plan
- Reset: hold reset 3 cycles with all inputs 1 -> every s_*valid, m*_ready, m*_rvalid and m1_bvalid is 0; after release with no requests, the block stays IDLE.
- IFU read: m0_arvalid with araddr 0x80000000 at cycle 1 -> s_arvalid = 1, s_arid = 0, s_araddr = 0x80000000 at cycle 2. After 4-cycle slave delay, s_rdata 0x00000413 -> m0_rvalid = 1, m0_rdata = 0x00000413; IDLE the cycle after the r handshake.
- Tie: m0 and m1 both assert arvalid continuously for 4 transactions -> grant order m0, m1, m0, m1; s_arid 0, 1, 0, 1.
- Write with contention: m1 writes 0xdeadbeef, strb 0xf to 0x80001000; slave bvalid arrives 5 cycles after W. m0_arvalid rises mid-write -> m0_arready stays 0 until WR completes, then RD0 is granted. Slave sees awid 1, wlast 1.
- Backpressure: in RD1, s_rvalid high while m1_rready is low for 3 cycles -> s_rready is 0 and state holds; completion on the 4th cycle when m1_rready = 1.
- Mid-operation reset: reset asserted in RD0 with s_rvalid high -> m0_rvalid and s_rready drop to 0 without waiting for a clock edge; next request after release is granted normally.

Source files
------------

// File: rtl/axi_arbiter.sv
// Two-master to one-slave AXI4 arbiter (IFU read-only, LSU read/write).
// One outstanding single-beat transaction, round-robin granted per transaction.
module axi_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [2:0]  m0_arsize,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [2:0]  m1_arsize,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_awaddr,
    input  logic [2:0]  m1_awsize,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [1:0]  m1_bresp,
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awid,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    output logic        s_wvalid,
    input  logic        s_wready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_bvalid,
    output logic        s_bready,
    input  logic [1:0]  s_bresp,
    input  logic [3:0]  s_bid
);

    typedef enum logic [1:0] {IDLE, RD0, RD1, WR} state_t;

    state_t state, state_nx;
    logic   addr_done, addr_done_nx;
    logic   wdat_done, wdat_done_nx;
    logic   last_grant, last_grant_nx;
    logic   req0, req1;
    logic   unused;

    assign unused = ^{s_rlast, s_rid, s_bid};
    assign req0   = m0_arvalid;
    assign req1   = m1_arvalid | m1_awvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_done  <= 1'b0;
            wdat_done  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            addr_done  <= addr_done_nx;
            wdat_done  <= wdat_done_nx;
            last_grant <= last_grant_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        addr_done_nx  = addr_done;
        wdat_done_nx  = wdat_done;
        last_grant_nx = last_grant;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = 32'h0;
        m0_rresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = 32'h0;
        m1_rresp   = 2'b00;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_araddr   = 32'h0;
        s_arid     = 4'h0;
        s_arlen    = 8'h0;
        s_arsize   = 3'h0;
        s_arburst  = 2'b00;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = 32'h0;
        s_awid     = 4'h0;
        s_awlen    = 8'h0;
        s_awsize   = 3'h0;
        s_awburst  = 2'b00;
        s_wvalid   = 1'b0;
        s_wdata    = 32'h0;
        s_wstrb    = 4'h0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;
        unique case (state)
            IDLE: begin
                // on a tie, the master that did not win last time goes
                if (req1 && (!req0 || !last_grant)) begin
                    state_nx      = m1_arvalid ? RD1 : WR;
                    last_grant_nx = 1'b1;
                end else if (req0) begin
                    state_nx      = RD0;
                    last_grant_nx = 1'b0;
                end
            end
            RD0: begin
                s_arvalid  = m0_arvalid & ~addr_done;
                m0_arready = s_arready & ~addr_done;
                s_araddr   = m0_araddr;
                s_arsize   = m0_arsize;
                s_arburst  = 2'b01;
                s_rready   = m0_rready;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                if (m0_arvalid && s_arready && !addr_done)
                    addr_done_nx = 1'b1;
                if (s_rvalid && m0_rready) begin
                    state_nx     = IDLE;
                    addr_done_nx = 1'b0;
                    wdat_done_nx = 1'b0;
                end
            end
            RD1: begin
                s_arvalid  = m1_arvalid & ~addr_done;
                m1_arready = s_arready & ~addr_done;
                s_araddr   = m1_araddr;
                s_arsize   = m1_arsize;
                s_arid     = 4'h1;
                s_arburst  = 2'b01;
                s_rready   = m1_rready;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                if (m1_arvalid && s_arready && !addr_done)
                    addr_done_nx = 1'b1;
                if (s_rvalid && m1_rready) begin
                    state_nx     = IDLE;
                    addr_done_nx = 1'b0;
                    wdat_done_nx = 1'b0;
                end
            end
            WR: begin
                s_awvalid  = m1_awvalid & ~addr_done;
                m1_awready = s_awready & ~addr_done;
                s_awaddr   = m1_awaddr;
                s_awsize   = m1_awsize;
                s_awid     = 4'h1;
                s_awburst  = 2'b01;
                s_wvalid   = m1_wvalid & ~wdat_done;
                m1_wready  = s_wready & ~wdat_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wlast    = 1'b1;
                s_bready   = m1_bready;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
                if (m1_awvalid && s_awready && !addr_done)
                    addr_done_nx = 1'b1;
                if (m1_wvalid && s_wready && !wdat_done)
                    wdat_done_nx = 1'b1;
                if (s_bvalid && m1_bready) begin
                    state_nx     = IDLE;
                    addr_done_nx = 1'b0;
                    wdat_done_nx = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: behavioural SRAM slave, master drivers,
// and a handshake monitor checking against queued expectations.
module tb_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [2:0]  m1_awsize;
    logic [3:0]  m1_wstrb;
    logic        m1_bvalid, m1_bready;
    logic [1:0]  m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen, s_awlen;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awid, s_wstrb, s_bid;
    logic        s_bvalid, s_bready;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  id;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_ar[$], exp_r0[$], exp_r1[$], exp_aw[$], exp_w[$], exp_b[$];
    int errors = 0;
    int checks = 0;
    int rd_delay = 1;
    int b_delay = 1;
    logic [31:0] mem [logic [31:0]];

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_0100;

    always #5 clk = ~clk;

    axi_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bresp(s_bresp), .s_bid(s_bid)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] id, input logic [3:0] strb,
                                input logic [1:0] resp);
        exp_t e;
        e.a = a;
        e.d = d;
        e.id = id;
        e.strb = strb;
        e.resp = resp;
        return e;
    endfunction

    // Read side of the SRAM slave; unmapped addresses answer SLVERR.
    initial begin : rd_slave
        logic hs;
        logic [31:0] a;
        logic [3:0] id;
        s_arready = 1; s_rvalid = 1; s_rdata = '1;
        s_rresp = '1; s_rlast = 1; s_rid = '1;
        @(negedge reset);
        s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
        forever begin
            s_arready = 1;
            do begin
                @(negedge clk);
                hs = s_arvalid && s_arready && !reset;
                a = s_araddr;
                id = s_arid;
                @(posedge clk); #1;
            end while (!hs);
            s_arready = 0;
            repeat (rd_delay - 1) begin @(posedge clk); #1; end
            s_rvalid = 1;
            s_rid = id;
            s_rdata = mem.exists(a) ? mem[a] : 32'h0;
            s_rresp = mem.exists(a) ? 2'b00 : 2'b10;
            do begin
                @(negedge clk);
                hs = s_rready;
                @(posedge clk); #1;
            end while (!hs && !reset);
            s_rvalid = 0;
            s_rdata = 0;
            s_rresp = 0;
        end
    end

    // Write side: accepts AW and W in any order, B follows W by b_delay.
    initial begin : wr_slave
        logic ha, hw, hb, ga, gw;
        int cnt;
        logic [31:0] wa, wd;
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = '1; s_bid = '1;
        @(negedge reset);
        s_bvalid = 0; s_bresp = 0; s_bid = 0;
        forever begin
            ga = 0; gw = 0; cnt = 0;
            s_awready = 1;
            s_wready = 1;
            while (!(ga && gw && cnt >= b_delay)) begin
                @(negedge clk);
                ha = s_awvalid && s_awready;
                hw = s_wvalid && s_wready;
                if (ha) wa = s_awaddr;
                if (hw) wd = s_wdata;
                @(posedge clk); #1;
                if (gw) cnt++;
                if (ha) begin ga = 1; s_awready = 0; end
                if (hw) begin gw = 1; s_wready = 0; end
            end
            mem[wa] = wd;
            s_bvalid = 1;
            s_bid = 1;
            do begin
                @(negedge clk);
                hb = s_bready;
                @(posedge clk); #1;
            end while (!hb);
            s_bvalid = 0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    e = exp_ar.pop_front();
                    chk("ar_id", s_arid, e.id);
                    chk("ar_addr", s_araddr, e.a);
                    chk("ar_len", s_arlen, 0);
                    chk("ar_burst", s_arburst, 1);
                    chk("ar_size", s_arsize, 2);
                end
            end
            if (m0_rvalid && m0_rready) begin
                if (exp_r0.size() == 0) chk("r0_unexpected", 1, 0);
                else begin
                    e = exp_r0.pop_front();
                    chk("r0_data", m0_rdata, e.d);
                    chk("r0_resp", m0_rresp, e.resp);
                end
            end
            if (m1_rvalid && m1_rready) begin
                if (exp_r1.size() == 0) chk("r1_unexpected", 1, 0);
                else begin
                    e = exp_r1.pop_front();
                    chk("r1_data", m1_rdata, e.d);
                    chk("r1_resp", m1_rresp, e.resp);
                end
            end
            if (s_awvalid && s_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    e = exp_aw.pop_front();
                    chk("aw_addr", s_awaddr, e.a);
                    chk("aw_id", s_awid, e.id);
                    chk("aw_len", s_awlen, 0);
                    chk("aw_burst", s_awburst, 1);
                    chk("aw_size", s_awsize, 2);
                end
            end
            if (s_wvalid && s_wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    chk("w_data", s_wdata, e.d);
                    chk("w_strb", s_wstrb, e.strb);
                    chk("w_last", s_wlast, 1);
                end
            end
            if (m1_bvalid && m1_bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    chk("b_resp", m1_bresp, e.resp);
                end
            end
        end
    end

    task automatic do_read(input bit m, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_resp,
                           input bit push_ar, input int stall);
        logic arv, arr, rv, rr;
        bit done;
        if (push_ar) exp_ar.push_back(mk(addr, 0, {3'b0, m}, 0, 0));
        if (m) begin
            exp_r1.push_back(mk(addr, exp_d, 0, 0, exp_resp));
            m1_araddr = addr; m1_arsize = 3'd2;
            m1_arvalid = 1; m1_rready = (stall == 0);
        end else begin
            exp_r0.push_back(mk(addr, exp_d, 0, 0, exp_resp));
            m0_araddr = addr; m0_arsize = 3'd2;
            m0_arvalid = 1; m0_rready = (stall == 0);
        end
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            arv = m ? m1_arvalid : m0_arvalid;
            arr = m ? m1_arready : m0_arready;
            rv  = m ? m1_rvalid  : m0_rvalid;
            rr  = m ? m1_rready  : m0_rready;
            if (rv && !rr && stall > 0) begin
                chk("bp_s_rready", s_rready, 0);
                stall--;
            end
            @(posedge clk); #1;
            if (arv && arr) begin
                if (m) m1_arvalid = 0; else m0_arvalid = 0;
            end
            if (rv && rr) done = 1;
            if (stall == 0) begin
                if (m) m1_rready = 1; else m0_rready = 1;
            end
        end
        if (!done) chk("read_timeout", 1, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lag);
        logic ha, hw, hb;
        bit done;
        exp_aw.push_back(mk(addr, 0, 1, 0, 0));
        exp_w.push_back(mk(0, data, 0, strb, 0));
        exp_b.push_back(mk(0, 0, 0, 0, 0));
        m1_awaddr = addr; m1_awsize = 3'd2; m1_awvalid = 1;
        m1_wdata = data; m1_wstrb = strb; m1_wvalid = (w_lag == 0);
        m1_bready = 1;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            ha = m1_awvalid && m1_awready;
            hw = m1_wvalid && m1_wready;
            hb = m1_bvalid && m1_bready;
            if (m0_arvalid) chk("wr_m0_blocked", {m0_arready, s_arvalid}, 0);
            @(posedge clk); #1;
            if (ha) m1_awvalid = 0;
            if (hw) m1_wvalid = 0;
            if (hb) done = 1;
            if (n + 1 == w_lag) m1_wvalid = 1;
        end
        if (!done) chk("write_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        bit hs;
        int n;
        mem[A0] = 32'h0000_0413;
        mem[A1] = 32'h1234_5678;
        m0_arvalid = 1; m0_araddr = '1; m0_arsize = '1; m0_rready = 1;
        m1_arvalid = 1; m1_araddr = '1; m1_arsize = '1; m1_rready = 1;
        m1_awvalid = 1; m1_awaddr = '1; m1_awsize = '1;
        m1_wvalid = 1; m1_wdata = '1; m1_wstrb = '1; m1_bready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_side", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        chk("rst_m_ready", {m0_arready, m1_arready, m1_awready, m1_wready}, 0);
        chk("rst_m_resp", {m0_rvalid, m1_rvalid, m1_bvalid}, 0);
        chk("rst_data", s_araddr | s_awaddr | s_wdata | m0_rdata | m1_rdata, 0);
        m0_arvalid = 0; m0_araddr = 0; m0_arsize = 0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_arsize = 0; m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = 0; m1_awsize = 0;
        m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_bready = 0;
        #1 reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset",
                {s_arvalid, s_awvalid, s_wvalid, m0_arready, m1_arready}, 0);
        end

        rd_delay = 4;
        @(posedge clk); #1;
        fork
            do_read(0, A0, 32'h0000_0413, 2'b00, 1, 0);
            begin
                @(negedge clk);
                chk("arb_latency_idle", s_arvalid, 0);
                @(negedge clk);
                chk("arb_latency_grant", s_arvalid, 1);
            end
        join
        @(negedge clk);
        chk("idle_after_read", {s_arvalid, s_rready, m0_rvalid, m0_arready}, 0);

        rd_delay = 1;
        @(posedge clk); #1;
        do_read(1, A1, 32'h1234_5678, 2'b00, 1, 3);
        do_read(1, 32'h9000_0000, 32'h0, 2'b10, 1, 0);

        exp_ar.push_back(mk(A0, 0, 0, 0, 0));
        exp_ar.push_back(mk(A1, 0, 1, 0, 0));
        exp_ar.push_back(mk(A0, 0, 0, 0, 0));
        exp_ar.push_back(mk(A1, 0, 1, 0, 0));
        fork
            begin
                do_read(0, A0, 32'h0000_0413, 2'b00, 0, 0);
                do_read(0, A0, 32'h0000_0413, 2'b00, 0, 0);
            end
            begin
                do_read(1, A1, 32'h1234_5678, 2'b00, 0, 0);
                do_read(1, A1, 32'h1234_5678, 2'b00, 0, 0);
            end
        join

        b_delay = 5;
        fork
            do_write(32'h8000_1000, 32'hdead_beef, 4'hf, 0);
            begin
                repeat (2) begin @(posedge clk); #1; end
                do_read(0, A0, 32'h0000_0413, 2'b00, 1, 0);
            end
        join
        do_write(32'h8000_1004, 32'hcafe_f00d, 4'h3, 2);
        do_read(1, 32'h8000_1000, 32'hdead_beef, 2'b00, 1, 0);

        m0_araddr = A0; m0_rready = 1; m0_arvalid = 1;
        exp_ar.push_back(mk(A0, 0, 0, 0, 0));
        hs = 0;
        for (n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            hs = m0_arvalid && m0_arready;
            @(posedge clk); #1;
        end
        m0_arvalid = 0;
        if (!hs) chk("rst_ar_timeout", 1, 0);
        #1;
        for (n = 0; n < 20 && !s_rvalid; n++) begin @(posedge clk); #2; end
        chk("rst_pre_m0_rvalid", m0_rvalid, 1);
        chk("rst_pre_s_rready", s_rready, 1);
        #1 reset = 1;
        #1;
        chk("rst_async_m0_rvalid", m0_rvalid, 0);
        chk("rst_async_s_rready", s_rready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        do_read(0, A0, 32'h0000_0413, 2'b00, 1, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_ar.size() + exp_r0.size() + exp_r1.size()
            + exp_aw.size() + exp_w.size() + exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
